// File: rtl/xsleenacore_palette_arbiter.sv
// Palette RAM arbiter: video lookups own the RAM pair, CPU writes are posted
// through a small FIFO and CPU reads wait for it to drain before issuing.
module xsleenacore_palette_arbiter #(
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_MAX = 32
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_ready,
  input  logic       pix_slot,
  input  logic       BLKn,
  input  logic [8:0] vid_addr,
  output logic [8:0] pal_addr,
  output logic       pal_cs_lsb,
  output logic       pal_cs_msb,
  output logic       pal_we,
  output logic [7:0] pal_din,
  input  logic [7:0] pal_q_lsb,
  input  logic [7:0] pal_q_msb,
  output logic       vid_stolen,
  output logic       wbuf_full
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_DRAIN,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wack_q, wack_d;
  logic [9:0]    raddr_q, raddr_d;

  logic [9:0] wb_addr [WBUF_DEPTH];
  logic [7:0] wb_data [WBUF_DEPTH];

  logic empty, full, video, pend;
  logic op_avail, sat, steal, grant;
  logic push, pop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CW'(WBUF_DEPTH));
    // Video is gated by reset so the RAM sees no enables while held.
    video    = pix_slot & BLKn & RSTn;
    op_avail = !empty | (state_q == RD_ISSUE);
    pend     = !empty | (state_q == RD_DRAIN)
             | (state_q == RD_ISSUE);
    sat      = (starve_q == SW'(STARVE_MAX));
    steal    = video & sat & op_avail;
    grant    = op_avail & (!video | steal);
    pop      = grant & !empty;
  end

  always_comb begin
    pal_addr   = '0;
    pal_cs_lsb = 1'b0;
    pal_cs_msb = 1'b0;
    pal_we     = 1'b0;
    pal_din    = '0;
    vid_stolen = steal;
    if (video && !steal) begin
      pal_addr   = vid_addr;
      pal_cs_lsb = 1'b1;
      pal_cs_msb = 1'b1;
    end else if (pop) begin
      pal_addr   = wb_addr[rptr_q][8:0];
      pal_cs_lsb = !wb_addr[rptr_q][9];
      pal_cs_msb = wb_addr[rptr_q][9];
      pal_we     = 1'b1;
      pal_din    = wb_data[rptr_q];
    end else if (grant) begin
      pal_addr   = raddr_q[8:0];
      pal_cs_lsb = !raddr_q[9];
      pal_cs_msb = raddr_q[9];
    end
  end

  always_comb begin
    // wack_q masks the still-held request of a write just acknowledged.
    push    = cpu_req & !cpu_rw & !full & !wack_q
            & (state_q == IDLE);
    wack_d  = push;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    state_d = state_q;
    raddr_d = raddr_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && cpu_rw && !wack_q) begin
          state_d = RD_DRAIN;
          raddr_d = cpu_addr;
        end
      end
      RD_DRAIN: begin
        if (!cpu_req) state_d = IDLE;
        else if (empty) state_d = RD_ISSUE;
      end
      RD_ISSUE: begin
        if (!cpu_req) state_d = IDLE;
        else if (grant) state_d = RD_WAIT;
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant || !pend) starve_d = '0;
    else if (!sat) starve_d = starve_q + SW'(1);
    else starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      wack_q   <= 1'b0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      wack_q   <= wack_d;
      raddr_q  <= raddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wptr_q] <= cpu_addr;
      wb_data[wptr_q] <= cpu_din;
    end
  end

  assign cpu_ready = wack_q | (state_q == RD_WAIT);
  assign cpu_dout  = (state_q == RD_WAIT)
                   ? (raddr_q[9] ? pal_q_msb : pal_q_lsb)
                   : 8'hFF;
  assign wbuf_full = full;

endmodule

// File: tb/tb_xsleenacore_palette_arbiter.sv
// Bench for xsleenacore_palette_arbiter: palette RAM model, write-order
// scoreboard, vector table, directed corner sequences and random traffic.
module tb_xsleenacore_palette_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 32;

  logic       clk = 0;
  logic       RSTn = 0;
  logic       cpu_req = 0, cpu_rw = 0;
  logic [9:0] cpu_addr = 0;
  logic [7:0] cpu_din = 0;
  logic [7:0] cpu_dout;
  logic       cpu_ready;
  logic       pix_slot = 0, BLKn = 0;
  logic [8:0] vid_addr = 0;
  logic [8:0] pal_addr;
  logic       pal_cs_lsb, pal_cs_msb, pal_we;
  logic [7:0] pal_din;
  logic [7:0] pal_q_lsb = 0, pal_q_msb = 0;
  logic       vid_stolen, wbuf_full;

  xsleenacore_palette_arbiter #(.WBUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .RSTn(RSTn),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .pix_slot(pix_slot), .BLKn(BLKn), .vid_addr(vid_addr),
    .pal_addr(pal_addr), .pal_cs_lsb(pal_cs_lsb), .pal_cs_msb(pal_cs_msb),
    .pal_we(pal_we), .pal_din(pal_din),
    .pal_q_lsb(pal_q_lsb), .pal_q_msb(pal_q_msb),
    .vid_stolen(vid_stolen), .wbuf_full(wbuf_full)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc_n = 0;
  int mode = 4;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [7:0] init_lsb(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction
  function automatic logic [7:0] init_msb(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  // external synchronous RAM pair, fed from values latched mid-cycle
  logic [7:0] ram_lsb [512];
  logic [7:0] ram_msb [512];
  logic       ram_init = 0;
  logic [8:0] l_addr = 0;
  logic       l_lsb = 0, l_msb = 0, l_we = 0;
  logic [7:0] l_din = 0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 512; i++) begin
        ram_lsb[i] <= init_lsb(i);
        ram_msb[i] <= init_msb(i);
      end
      ram_init <= 1;
    end else begin
      if (l_lsb) begin
        if (l_we) ram_lsb[l_addr] <= l_din;
        else pal_q_lsb <= ram_lsb[l_addr];
      end
      if (l_msb) begin
        if (l_we) ram_msb[l_addr] <= l_din;
        else pal_q_msb <= ram_msb[l_addr];
      end
    end
  end

  // scoreboard: accepted writes must reach the RAM in order
  logic [17:0] wq[$];
  logic [7:0]  sh_lsb [512];
  logic [7:0]  sh_msb [512];
  logic        sh_init = 0;
  int we_cnt = 0, last_we_cyc = -1;
  logic [8:0] last_we_addr = 0;
  logic [7:0] last_we_din = 0;
  logic       last_we_lsb = 0;
  int steal_cnt = 0, last_steal_cyc = -1;
  logic [8:0] steal_addr = 0;
  int rd_cyc = -1;
  logic rd_msb = 0;

  always @(negedge clk) begin
    logic video;
    logic [17:0] e;
    logic [7:0] expd;
    if (!sh_init) begin
      for (int i = 0; i < 512; i++) begin
        sh_lsb[i] = init_lsb(i);
        sh_msb[i] = init_msb(i);
      end
      sh_init = 1;
    end
    l_addr = pal_addr; l_lsb = pal_cs_lsb; l_msb = pal_cs_msb;
    l_we = pal_we; l_din = pal_din;
    if (!RSTn) begin
      wq.delete();
    end else begin
      video = pix_slot & BLKn;
      if (video && !vid_stolen)
        chk("vid_pass", {pal_cs_lsb, pal_cs_msb, pal_we, 3'b0, pal_addr},
            {3'b110, 3'b0, vid_addr});
      if (vid_stolen) begin
        chk("steal_in_video", 32'(video), 1);
        steal_cnt++;
        last_steal_cyc = cyc_n;
        steal_addr = pal_addr;
      end
      if (!cpu_ready) chk("dout_idle", cpu_dout, 8'hFF);
      if (cpu_ready && cpu_req && !cpu_rw) wq.push_back({cpu_addr, cpu_din});
      chk("wbuf_full", 32'(wbuf_full), 32'(wq.size() == DEPTH));
      if (pal_we) begin
        chk("we_expected", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("we_order", {pal_cs_msb, pal_cs_lsb, pal_addr, pal_din},
              {e[17], !e[17], e[16:8], e[7:0]});
          if (e[17]) sh_msb[e[16:8]] = e[7:0];
          else sh_lsb[e[16:8]] = e[7:0];
        end
        we_cnt++;
        last_we_cyc = cyc_n;
        last_we_addr = pal_addr;
        last_we_din = pal_din;
        last_we_lsb = pal_cs_lsb;
      end else if ((pal_cs_lsb || pal_cs_msb) && !(video && !vid_stolen)) begin
        chk("rd_cs_onehot", 32'(pal_cs_lsb ^ pal_cs_msb), 1);
        rd_cyc = cyc_n;
        rd_msb = pal_cs_msb;
      end
      if (cpu_ready && cpu_req && cpu_rw) begin
        chk("rd_after_wr", wq.size(), 0);
        expd = cpu_addr[9] ? sh_msb[cpu_addr[8:0]] : sh_lsb[cpu_addr[8:0]];
        chk("rd_data", cpu_dout, expd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    cyc_n++;
    vid_addr = 9'($urandom);
    case (mode)
      0: begin pix_slot = 1'($urandom_range(0, 1)); BLKn = 0; end
      1: begin pix_slot = 1; BLKn = 1; end
      2: begin pix_slot = ~pix_slot; BLKn = 1; end
      3: begin
        pix_slot = 1'($urandom_range(0, 1));
        BLKn = ($urandom_range(0, 4) != 0);
      end
      default: ;
    endcase
  endtask

  task automatic idle(input int n);
    cpu_req = 0;
    repeat (n) cyc();
  endtask

  task automatic settle_neg();
    @(negedge clk); #1;
  endtask

  // ends in the acknowledge cycle with the request still held
  task automatic cpu_op(input logic rw, input logic [9:0] a,
                        input logic [7:0] d, input int maxc,
                        output int lat, output logic [7:0] q);
    cpu_req = 1; cpu_rw = rw; cpu_addr = a; cpu_din = d;
    lat = 0; q = 8'hFF;
    do begin cyc(); #1; lat++; end while (!cpu_ready && lat < maxc);
    chk("op_ack", 32'(cpu_ready), 1);
    if (cpu_ready) q = cpu_dout;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(cpu_ready), 0);
    chk({tag, "_dout"}, cpu_dout, 8'hFF);
    chk({tag, "_cs"}, {pal_cs_lsb, pal_cs_msb}, 0);
    chk({tag, "_we"}, 32'(pal_we), 0);
    chk({tag, "_stolen"}, 32'(vid_stolen), 0);
    chk({tag, "_full"}, 32'(wbuf_full), 0);
    chk({tag, "_addr"}, pal_addr, 0);
    chk({tag, "_din"}, pal_din, 0);
  endtask

  typedef struct {
    logic       ps;
    logic       blk;
    logic [8:0] va;
    logic       ecs;
    logic [8:0] eaddr;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int lat, r0, we0, st0, bad;
    logic [7:0] q;

    vt[0] = '{1'b1, 1'b1, 9'h1AB, 1'b1, 9'h1AB};
    vt[1] = '{1'b0, 1'b1, 9'h0F0, 1'b0, 9'h000};
    vt[2] = '{1'b1, 1'b0, 9'h155, 1'b0, 9'h000};
    vt[3] = '{1'b0, 1'b0, 9'h0AA, 1'b0, 9'h000};
    vt[4] = '{1'b1, 1'b1, 9'h000, 1'b1, 9'h000};
    vt[5] = '{1'b1, 1'b1, 9'h1FF, 1'b1, 9'h1FF};

    // reset held with video slots active
    mode = 1;
    repeat (3) cyc();
    #1 check_reset_outs("rst");
    RSTn = 1;

    mode = 4;
    for (int i = 0; i < 6; i++) begin
      cyc();
      pix_slot = vt[i].ps; BLKn = vt[i].blk; vid_addr = vt[i].va;
      #1;
      chk($sformatf("vec%0d", i),
          {pal_cs_lsb, pal_cs_msb, pal_we, pal_addr},
          {vt[i].ecs, vt[i].ecs, 1'b0, vt[i].eaddr});
    end

    // single write during blanking
    mode = 0; idle(2);
    we0 = we_cnt;
    cpu_op(0, 10'h005, 8'h3A, 10, lat, q);
    r0 = cyc_n;
    chk("blank_wr_lat", lat, 1);
    cyc(); cpu_req = 0; cyc(); settle_neg();
    chk("blank_we_cnt", we_cnt - we0, 1);
    chk("blank_we_when", 32'(last_we_cyc >= r0 && last_we_cyc <= r0 + 1), 1);
    chk("blank_we_fields", {last_we_lsb, last_we_addr, last_we_din},
        {1'b1, 9'h005, 8'h3A});

    // five writes against continuous video: fill, stall, steal
    mode = 1; idle(2);
    st0 = steal_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu_op(0, 10'(16 + i), 8'(8'hA0 + i), 10, lat, q);
      if (i == 0) r0 = cyc_n;
      chk("burst_wr_lat", lat, 1);
      cyc();
    end
    chk("burst_full", 32'(wbuf_full), 1);
    cpu_op(0, 10'h214, 8'hA4, 100, lat, q);
    chk("burst_stalled", 32'(lat > 2), 1);
    chk("burst_steals", steal_cnt - st0, 1);
    chk("burst_steal_cyc", last_steal_cyc, r0 + SMAX);
    chk("burst_steal_addr", steal_addr, 9'd16);
    chk("burst_ack_after", 32'(cyc_n > last_steal_cyc), 1);
    cyc(); cpu_req = 0;
    mode = 0; idle(10);

    // read after a buffered MSB write
    mode = 1; idle(2);
    cpu_op(0, 10'h205, 8'h0F, 10, lat, q);
    cyc();
    cpu_op(1, 10'h205, 8'h00, 200, lat, q);
    chk("raw_data", q, 8'h0F);
    chk("raw_from_msb", 32'(rd_msb), 1);
    chk("raw_order", 32'(rd_cyc > last_we_cyc), 1);
    chk("raw_we_addr", last_we_addr, 9'h005);
    cyc(); cpu_req = 0;

    // three buffered entries drained through alternating slots
    mode = 0; idle(4);
    mode = 1; idle(2);
    for (int i = 0; i < 3; i++) begin
      cpu_op(0, 10'(10'h100 + 10'(i * 7)), 8'(8'h60 + i), 10, lat, q);
      cyc();
    end
    we0 = we_cnt; st0 = steal_cnt;
    mode = 2; cpu_req = 0;
    repeat (5) cyc();
    settle_neg();
    chk("toggle_drain", we_cnt - we0, 3);
    chk("toggle_nosteal", steal_cnt - st0, 0);
    chk("toggle_empty", wq.size(), 0);

    // read dropped while waiting for a slot
    mode = 1; idle(3);
    cpu_req = 1; cpu_rw = 1; cpu_addr = 10'h033;
    cyc(); cyc();
    cpu_req = 0;
    bad = 0; st0 = steal_cnt;
    for (int i = 0; i < 40; i++) begin
      cyc(); #1;
      if (cpu_ready || cpu_dout != 8'hFF) bad++;
    end
    mode = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      if (cpu_ready || pal_cs_lsb || pal_cs_msb) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_nosteal", steal_cnt - st0, 0);

    // reset with two writes still buffered
    mode = 1; idle(2);
    for (int i = 0; i < 2; i++) begin
      cpu_op(0, 10'(10'h040 + 10'(i)), 8'(8'hC0 + i), 10, lat, q);
      cyc();
    end
    cpu_req = 0;
    we0 = we_cnt;
    cyc();
    RSTn = 0;
    #1 check_reset_outs("midrst");
    cyc(); cyc();
    RSTn = 1;
    mode = 0; idle(10); settle_neg();
    chk("rst_no_we", we_cnt - we0, 0);
    chk("rst_full", 32'(wbuf_full), 0);
    cpu_op(0, 10'h2AA, 8'h77, 10, lat, q);
    chk("post_rst_lat", lat, 1);
    cyc(); cpu_req = 0;
    idle(3);

    // random traffic
    mode = 3;
    for (int n = 0; n < 200; n++) begin
      logic rw;
      logic [9:0] a;
      rw = 1'($urandom_range(0, 2) == 0);
      a = {1'($urandom_range(0, 1)), 6'b0, 3'($urandom)};
      cpu_op(rw, a, 8'($urandom), 400, lat, q);
      cyc(); cpu_req = 0;
      idle($urandom_range(0, 2));
    end
    mode = 0; idle(20); settle_neg();
    chk("final_drain", wq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
